rw_mode_scheduler: RTL and testbench
====================================

RW_MODE_SCHEDULER -- requirements
Module: rw_mode_scheduler

Interface
REQ-001 SHALL have parameter DEPTH_WR, default 16: write-queue capacity in entries.
REQ-002 SHALL have parameter LOW_WM, default 2: write-mode exit threshold.
REQ-003 SHALL have parameter HIGH_WM, default 12: forced write-mode entry threshold; LOW_WM < HIGH_WM <= DEPTH_WR.
REQ-004 SHALL have parameter TURN_CYC, default 4: bus-turnaround idle cycles, >= 1.
REQ-005 SHALL have parameter MAX_DRAIN, default 8: write-burst limit under the guard feature.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port wr_in, input, 1: one write entered the write queue this cycle.
REQ-009 SHALL have port rd_req, input, 1: at least one read is pending.
REQ-010 SHALL have port wr_req, input, 1: at least one write is pending.
REQ-011 SHALL have port rd_grant_o, output, 1: issue a read this cycle.
REQ-012 SHALL have port wr_grant_o, output, 1: issue a write this cycle.
REQ-013 SHALL have port mode_o, output, 1: 1 = write mode, 0 = read mode.
REQ-014 SHALL have port turn_o, output, 1: turnaround in progress.
REQ-015 SHALL have port wr_cnt_o, output, $clog2(DEPTH_WR+1): write occupancy.
REQ-016 SHALL have ports lwm_o and hwm_o, outputs, 1 each: wr_cnt_o <= LOW_WM and wr_cnt_o >= HIGH_WM, combinational.
REQ-017 SHALL have port err_o, output, 1: sticky counter overflow/underflow flag.

Function
REQ-018 SHALL implement FSM states S_READ, S_TURN_RW, S_WRITE, S_TURN_WR.
REQ-019 S_READ SHALL go to S_TURN_RW when hwm_o=1, or when rd_req=0 and wr_cnt_o>0.
REQ-020 S_WRITE SHALL go to S_TURN_WR when wr_cnt_o=0, or when lwm_o=1 and rd_req=1.
REQ-021 Each turn state SHALL last exactly TURN_CYC cycles via a down-counter, then enter S_WRITE (from S_TURN_RW) or S_READ (from S_TURN_WR).
REQ-022 rd_grant_o SHALL equal rd_req in S_READ and 0 elsewhere.
REQ-023 wr_grant_o SHALL equal wr_req in S_WRITE and 0 elsewhere; grants SHALL be combinational, with zero latency from state and request.
REQ-024 mode_o SHALL be 1 in S_TURN_RW and S_WRITE; turn_o SHALL be 1 only in the turn states.
REQ-025 Write count: +1 on wr_in only; -1 on wr_grant_o only; unchanged when both occur in the same cycle.
REQ-026 wr_in at count DEPTH_WR SHALL hold the count and set err_o.
REQ-027 wr_grant_o at count 0 SHALL hold 0 and set err_o.
REQ-028 FSM transitions SHALL use the registered (pre-update) count.

Reset
REQ-029 On rst=1 at a clock edge: state S_READ, count 0, turn counter 0, drain counter 0, err_o 0.
REQ-030 Resulting reset outputs: rd_grant_o=rd_req, wr_grant_o=0, mode_o=0, turn_o=0, lwm_o=1, hwm_o=0.
REQ-031 Reset asserted mid-turnaround or mid-drain SHALL abort the operation on that edge with no further grant.

Configuration
REQ-032 With macro RD_STARVE_GUARD_EN defined: a drain counter SHALL count write grants in S_WRITE, clear on entry to S_WRITE, and force S_WRITE to S_TURN_WR when it reaches MAX_DRAIN and rd_req=1.
REQ-033 Without RD_STARVE_GUARD_EN: no drain counter SHALL be built, and the S_WRITE exit SHALL follow REQ-020 only.

Structure
REQ-034 State enum and mode encodings (WR_MODE=1, RD_MODE=0) SHALL live in shared package bank_sched_pkg.
REQ-035 The turnaround down-counter SHALL be sub-module turnaround_timer, with inputs start and TURN_CYC and output done.

Verification
REQ-036 Reset, then 12 wr_in pulses with rd_req=1 -> on cycle 12 hwm_o=1; next cycle S_TURN_RW for 4 cycles with no grants; then mode_o=1 and wr_grant_o follows wr_req.
REQ-037 In S_WRITE with count 3, rd_req=1, grant 1 write -> count 2, lwm_o=1; next cycle S_TURN_WR for 4 cycles; then rd_grant_o=1.
REQ-038 wr_in and wr_grant_o in the same cycle at count 5 -> count stays 5, err_o=0.
REQ-039 16 wr_in then 1 more -> count 16, err_o=1 and stays 1 until rst.
REQ-040 RD_STARVE_GUARD_EN, count 16, rd_req=1 -> exactly 8 write grants, then S_TURN_WR; without the macro -> writes drain until count 2.
REQ-041 rst pulsed in the 2nd cycle of S_TURN_RW -> next cycle S_READ, mode_o=0, count 0.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared types for the read/write bus scheduler: FSM state encoding and bus mode values.
package bank_sched_pkg;

    typedef enum logic [1:0] {
        S_READ    = 2'd0,
        S_TURN_RW = 2'd1,
        S_WRITE   = 2'd2,
        S_TURN_WR = 2'd3
    } sched_state_e;

    localparam logic WR_MODE = 1'b1;
    localparam logic RD_MODE = 1'b0;

    // The bus is already committed to writes while turning from read to write.
    function automatic logic mode_of(input sched_state_e s);
        return ((s == S_TURN_RW) || (s == S_WRITE)) ? WR_MODE : RD_MODE;
    endfunction

endpackage

// File: rtl/turnaround_timer.sv
// Bus-turnaround down-counter: a start pulse opens a window of exactly TURN_CYC cycles,
// the last of which has done=1.
module turnaround_timer #(
    parameter int TURN_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = TW'(TURN_CYC - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rw_mode_scheduler.sv
// Read/write mode scheduler with write-queue occupancy tracking and watermark-driven turnarounds.
// Optional macro RD_STARVE_GUARD_EN bounds each write burst to MAX_DRAIN grants while reads wait.
module rw_mode_scheduler
    import bank_sched_pkg::*;
#(
    parameter int DEPTH_WR  = 16,
    parameter int LOW_WM    = 2,
    parameter int HIGH_WM   = 12,
    parameter int TURN_CYC  = 4,
    parameter int MAX_DRAIN = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_in,
    input  logic                          rd_req,
    input  logic                          wr_req,
    output logic                          rd_grant_o,
    output logic                          wr_grant_o,
    output logic                          mode_o,
    output logic                          turn_o,
    output logic [$clog2(DEPTH_WR+1)-1:0] wr_cnt_o,
    output logic                          lwm_o,
    output logic                          hwm_o,
    output logic                          err_o
);

    localparam int CW = $clog2(DEPTH_WR + 1);

    if ((LOW_WM >= HIGH_WM) || (HIGH_WM > DEPTH_WR) || (TURN_CYC < 1) || (MAX_DRAIN < 1)) begin : g_bad_params
        $error("rw_mode_scheduler: illegal parameter combination");
    end

    sched_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timer_start;
    logic          turn_done;
    logic          drain_hit;

    turnaround_timer #(.TURN_CYC(TURN_CYC)) u_turn_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .done  (turn_done)
    );

`ifdef RD_STARVE_GUARD_EN
    localparam int DW = $clog2(MAX_DRAIN + 1);

    logic [DW-1:0] drain_q, drain_d;

    // Held at zero outside S_WRITE so every burst starts counting from scratch.
    always_comb begin
        drain_d = '0;
        if (state_q == S_WRITE) begin
            drain_d = (wr_grant_o && (drain_q != DW'(MAX_DRAIN))) ? drain_q + DW'(1) : drain_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q <= '0;
        end else begin
            drain_q <= drain_d;
        end
    end

    assign drain_hit = (state_q == S_WRITE) && (drain_d == DW'(MAX_DRAIN));
`else
    assign drain_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_READ;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_start = 1'b0;
        case (state_q)
            S_READ: begin
                if (hwm_o || (!rd_req && (cnt_q != '0))) begin
                    state_d     = S_TURN_RW;
                    timer_start = 1'b1;
                end
            end
            S_TURN_RW: begin
                if (turn_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                if ((cnt_q == '0) || (rd_req && (lwm_o || drain_hit))) begin
                    state_d     = S_TURN_WR;
                    timer_start = 1'b1;
                end
            end
            S_TURN_WR: begin
                if (turn_done) state_d = S_READ;
            end
            default: state_d = S_READ;
        endcase
    end

    always_comb begin
        rd_grant_o = (state_q == S_READ) && rd_req;
        wr_grant_o = (state_q == S_WRITE) && wr_req;
        mode_o     = mode_of(state_q);
        turn_o     = (state_q == S_TURN_RW) || (state_q == S_TURN_WR);
        wr_cnt_o   = cnt_q;
        lwm_o      = (cnt_q <= CW'(LOW_WM));
        hwm_o      = (cnt_q >= CW'(HIGH_WM));
        err_o      = err_q;
    end

    // A simultaneous enqueue and grant cancel out, so only one-sided changes can over/underflow.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (wr_in && !wr_grant_o) begin
            if (cnt_q == CW'(DEPTH_WR)) err_d = 1'b1;
            else                        cnt_d = cnt_q + CW'(1);
        end else if (!wr_in && wr_grant_o) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_rw_mode_scheduler.sv
// Directed bench for rw_mode_scheduler at default parameters.
module tb_rw_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_in = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_grant_o, wr_grant_o, mode_o, turn_o, lwm_o, hwm_o, err_o;
    logic [4:0] wr_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    rw_mode_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wr_in      (wr_in),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .rd_grant_o (rd_grant_o),
        .wr_grant_o (wr_grant_o),
        .mode_o     (mode_o),
        .turn_o     (turn_o),
        .wr_cnt_o   (wr_cnt_o),
        .lwm_o      (lwm_o),
        .hwm_o      (hwm_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int grants;
        int exp_grants;
        int exp_left;
        bit done_flag;

        // Reset state
        rd_req = 1'b1;
        tick();
        tick();
        chk("rst_rd_grant", rd_grant_o, 1);
        chk("rst_wr_grant", wr_grant_o, 0);
        chk("rst_mode", mode_o, 0);
        chk("rst_turn", turn_o, 0);
        chk("rst_lwm", lwm_o, 1);
        chk("rst_hwm", hwm_o, 0);
        chk("rst_cnt", wr_cnt_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;

        // Fill to the high watermark while reads keep the bus
        wr_in = 1'b1;
        repeat (11) tick();
        chk("fill11_hwm", hwm_o, 0);
        chk("fill11_cnt", wr_cnt_o, 11);
        tick();
        wr_in  = 1'b0;
        wr_req = 1'b1;
        #1;
        chk("fill12_cnt", wr_cnt_o, 12);
        chk("fill12_hwm", hwm_o, 1);
        chk("fill12_mode", mode_o, 0);
        chk("fill12_rd_grant", rd_grant_o, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("turn_rw%0d_turn", i), turn_o, 1);
            chk($sformatf("turn_rw%0d_mode", i), mode_o, 1);
            chk($sformatf("turn_rw%0d_grants", i), {rd_grant_o, wr_grant_o}, 0);
            tick();
        end
        chk("write_turn", turn_o, 0);
        chk("write_mode", mode_o, 1);
        chk("write_grant_req1", wr_grant_o, 1);
        wr_req = 1'b0;
        #1;
        chk("write_grant_req0", wr_grant_o, 0);
        wr_req = 1'b1;

        // Drain to the low watermark with reads pending
        repeat (9) tick();
        chk("drain_cnt3", wr_cnt_o, 3);
        chk("drain_cnt3_lwm", lwm_o, 0);
        tick();
        wr_req = 1'b0;
        #1;
        chk("drain_cnt2", wr_cnt_o, 2);
        chk("drain_cnt2_lwm", lwm_o, 1);
        chk("drain_cnt2_mode", mode_o, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("turn_wr%0d_turn", i), turn_o, 1);
            chk($sformatf("turn_wr%0d_mode", i), mode_o, 0);
            chk($sformatf("turn_wr%0d_rd_grant", i), rd_grant_o, 0);
            tick();
        end
        chk("back_read_rd_grant", rd_grant_o, 1);
        chk("back_read_turn", turn_o, 0);
        chk("back_read_cnt", wr_cnt_o, 2);

        // Enqueue and grant in the same cycle at count 5
        wr_in = 1'b1;
        repeat (3) tick();
        wr_in  = 1'b0;
        rd_req = 1'b0;
        chk("pre5_cnt", wr_cnt_o, 5);
        repeat (5) tick();
        chk("w5_mode", mode_o, 1);
        chk("w5_turn", turn_o, 0);
        wr_in  = 1'b1;
        wr_req = 1'b1;
        #1;
        chk("both_grant", wr_grant_o, 1);
        tick();
        chk("both_cnt", wr_cnt_o, 5);
        chk("both_err", err_o, 0);
        wr_in = 1'b0;
        tick();
        chk("single_grant_cnt", wr_cnt_o, 4);

        // Reset in the middle of a write burst
        rst = 1'b1;
        tick();
        chk("rst_mid_wr_grant", wr_grant_o, 0);
        chk("rst_mid_mode", mode_o, 0);
        chk("rst_mid_cnt", wr_cnt_o, 0);
        rst    = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b1;

        // Overflow: 16 enqueues then one more
        wr_in = 1'b1;
        repeat (16) tick();
        chk("full_cnt", wr_cnt_o, 16);
        chk("full_err", err_o, 0);
        tick();
        wr_in = 1'b0;
        #1;
        chk("ovf_cnt", wr_cnt_o, 16);
        chk("ovf_err", err_o, 1);
        done_flag = 1'b0;
        for (int i = 0; i < 10 && !done_flag; i++) begin
            if (mode_o && !turn_o) done_flag = 1'b1;
            else tick();
        end
        chk("reach_write_timeout", done_flag, 1);
        chk("ovf_err_sticky", err_o, 1);

        // Burst length with reads pending
`ifdef RD_STARVE_GUARD_EN
        exp_grants = 8;
        exp_left   = 8;
`else
        exp_grants = 14;
        exp_left   = 2;
`endif
        grants    = 0;
        done_flag = 1'b0;
        for (int i = 0; i < 40 && !done_flag; i++) begin
            wr_req = (wr_cnt_o > 5'd2);
            #1;
            if (turn_o) begin
                done_flag = 1'b1;
            end else begin
                grants += int'(wr_grant_o);
                tick();
            end
        end
        wr_req = 1'b0;
        chk("burst_timeout", done_flag, 1);
        chk("burst_grants", grants, exp_grants);
        chk("burst_cnt", wr_cnt_o, exp_left);
        chk("burst_mode", mode_o, 0);
        chk("burst_err_sticky", err_o, 1);

        // Reset in the 2nd cycle of a read-to-write turnaround
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        rd_req = 1'b0;
        wr_in  = 1'b1;
        tick();
        wr_in = 1'b0;
        tick();
        tick();
        chk("turn2_turn", turn_o, 1);
        chk("turn2_mode", mode_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_turn_mode", mode_o, 0);
        chk("rst_turn_turn", turn_o, 0);
        chk("rst_turn_cnt", wr_cnt_o, 0);
        chk("rst_turn_err", err_o, 0);

        // Underflow: grant while the queue is already empty
        wr_in = 1'b1;
        tick();
        wr_in = 1'b0;
        repeat (5) tick();
        chk("uf_mode", mode_o, 1);
        chk("uf_cnt1", wr_cnt_o, 1);
        wr_req = 1'b1;
        #1;
        chk("uf_grant1", wr_grant_o, 1);
        tick();
        chk("uf_cnt0", wr_cnt_o, 0);
        chk("uf_err_before", err_o, 0);
        chk("uf_grant0", wr_grant_o, 1);
        tick();
        chk("uf_cnt_hold", wr_cnt_o, 0);
        chk("uf_err", err_o, 1);
        chk("uf_turn", turn_o, 1);
        wr_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
